// File: rtl/fetch_queue_unit_pkg.sv
// fetch_pkg: shared definitions for the fetch queue unit.
//   - fetch_state_e   : fetch FSM encoding (IDLE / WAIT / DISCARD)
//   - ENT_*           : field indices of a queue entry; a field is XLEN wide,
//                       so field f lives at [f*XLEN +: XLEN]
//   - INST_ALIGN_MASK : clears the two low PC bits (word-aligned fetch)
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

    localparam int ENT_PC_IDX   = 0;
    localparam int ENT_INST_IDX = 1;
    localparam int ENT_PRED_IDX = 2;
    localparam int ENT_FIELDS   = 3;

    // Sliced to XLEN at the point of use.
    localparam logic [63:0] INST_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: bundle of the fetch unit's non-clock signals.
//   master : the fetch unit (drives ICache request, predictor query, queue head)
//   slave  : the surroundings (flow controller, ICache, predictor, decoder)
interface fetch_queue_unit_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic            ic_req_valid;
    logic [XLEN-1:0] ic_req_addr;
    logic            ic_resp_valid;
    logic [XLEN-1:0] ic_resp_inst;
    logic [XLEN-1:0] bp_pc;
    logic [XLEN-1:0] bp_inst;
    logic [XLEN-1:0] bp_next_pc;
    logic            out_valid;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pred_pc;
    logic            out_ready;

    modport master (
        input  flush, flush_pc, ic_resp_valid, ic_resp_inst, bp_next_pc, out_ready,
        output ic_req_valid, ic_req_addr, bp_pc, bp_inst,
               out_valid, out_inst, out_pc, out_pred_pc
    );

    modport slave (
        output flush, flush_pc, ic_resp_valid, ic_resp_inst, bp_next_pc, out_ready,
        input  ic_req_valid, ic_req_addr, bp_pc, bp_inst,
               out_valid, out_inst, out_pc, out_pred_pc
    );
endinterface

// File: rtl/fetch_entry_fifo.sv
// fetch_entry_fifo: DEPTH-entry circular buffer of WIDTH-bit entries.
//   clk, rst : clock, synchronous active-high reset
//   clear_i  : empty the buffer; wins over push_i and pop_i
//   push_i   : write data_i at the tail
//   pop_i    : drop the head (ignored when empty)
//   data_o   : head entry (registered storage)
//   count_o  : number of valid entries, 0..DEPTH
module fetch_entry_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (count_q != CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: single-outstanding ICache fetcher with branch-predictor
// lookup and a DEPTH-entry {pc, inst, pred_next_pc} queue toward decode.
//   clk, rst : clock, synchronous active-high reset
//   rdy      : global enable; when low nothing advances
//   bus      : flush/redirect, ICache req/resp, predictor query, queue head
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    fetch_queue_unit_if.master  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ENT_FIELDS * XLEN;

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [CW-1:0]   count;
    logic [EW-1:0]   head, push_data;
    logic            push, pop, clear, resp_take, req_valid;
    logic [XLEN-1:0] req_addr, flush_pc_al;

    assign flush_pc_al = bus.flush_pc & INST_ALIGN_MASK[XLEN-1:0];

    // The response is paired with fetch_pc_q, which still holds the
    // address of the outstanding request.
    assign bus.bp_pc   = fetch_pc_q;
    assign bus.bp_inst = bus.ic_resp_inst;

    assign resp_take = rdy && !bus.flush && (state_q == S_WAIT) && bus.ic_resp_valid;
    assign push      = resp_take;
    assign pop       = rdy && !bus.flush && bus.out_valid && bus.out_ready;
    assign clear     = rdy && bus.flush;

    always_comb begin
        push_data = '0;
        push_data[ENT_PC_IDX*XLEN   +: XLEN] = fetch_pc_q;
        push_data[ENT_INST_IDX*XLEN +: XLEN] = bus.ic_resp_inst;
        push_data[ENT_PRED_IDX*XLEN +: XLEN] = bus.bp_next_pc;
    end

    // Request is combinational so a response can re-issue in the same
    // cycle (one instruction per ICache latency). Credits use the
    // registered count only; a same-cycle pop frees nothing until later.
    always_comb begin
        req_valid = 1'b0;
        req_addr  = fetch_pc_q;
        if (rst) begin
            req_addr = RESET_PC;
        end else if (!bus.flush) begin
            case (state_q)
                S_IDLE: req_valid = (count < CW'(DEPTH));
                S_WAIT: if (bus.ic_resp_valid) begin
                    req_addr  = bus.bp_next_pc;
                    req_valid = ((count + CW'(1)) < CW'(DEPTH));
                end
                default: ;
            endcase
        end
    end

    assign bus.ic_req_valid = req_valid;
    assign bus.ic_req_addr  = req_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
        end else if (rdy) begin
            if (bus.flush) begin
                fetch_pc_q <= flush_pc_al;
                case (state_q)
                    // A response coinciding with the flush retires the
                    // outstanding request, so nothing is left to discard.
                    S_WAIT, S_DISCARD: state_q <= bus.ic_resp_valid ? S_IDLE : S_DISCARD;
                    default:           state_q <= S_IDLE;
                endcase
            end else begin
                case (state_q)
                    S_IDLE:    if (req_valid) state_q <= S_WAIT;
                    S_WAIT:    if (bus.ic_resp_valid) begin
                        fetch_pc_q <= bus.bp_next_pc;
                        state_q    <= req_valid ? S_WAIT : S_IDLE;
                    end
                    S_DISCARD: if (bus.ic_resp_valid) state_q <= S_IDLE;
                    default:   state_q <= S_IDLE;
                endcase
            end
        end
    end

    // A response with nothing outstanding is an ICache protocol error.
    always_ff @(posedge clk) begin
        if (!rst && rdy && state_q == S_IDLE) assert (!bus.ic_resp_valid);
    end

    fetch_entry_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .data_o  (head),
        .count_o (count)
    );

    assign bus.out_valid   = (count != '0);
    assign bus.out_pc      = head[ENT_PC_IDX*XLEN   +: XLEN];
    assign bus.out_inst    = head[ENT_INST_IDX*XLEN +: XLEN];
    assign bus.out_pred_pc = head[ENT_PRED_IDX*XLEN +: XLEN];
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed bench with an ICache/predictor model and an
// entry scoreboard (pushed on accepted responses, popped on head handshakes).
module tb_fetch_queue_unit;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pred;
    } ent_t;

    logic clk, rst, rdy;
    fetch_queue_unit_if #(.XLEN(32)) bus();

    fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];

    // ICache / predictor model state
    int          lat = 1;
    bit          ic_pend = 0;
    int          ic_wait = 0;
    logic [31:0] ic_addr = '0;
    bit          ovr_en = 0;
    logic [31:0] ovr_inst = '0;
    bit          disc = 0;
    bit          jump_en = 0;
    bit          arm_flush = 0;
    logic [31:0] exp_pc = '0;

    // per-cycle observations
    bit          req_now, fired, fire_ov, ov_now;
    logic [31:0] req_addr_now;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return (a << 4) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] pred_of(logic [31:0] a);
        return (jump_en && a == 32'h8) ? 32'h40 : a + 32'd4;
    endfunction

    always_comb bus.bp_next_pc = pred_of(bus.bp_pc);

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic cyc();
        logic [31:0] inst;
        ent_t        e;
        bit          resp, flushing, do_pop;
        resp  = 0;
        fired = 0;
        if (rdy && ic_pend) begin
            ic_wait--;
            if (ic_wait == 0) resp = 1;
        end
        inst = ovr_en ? ovr_inst : inst_of(ic_addr);
        bus.ic_resp_valid = resp;
        bus.ic_resp_inst  = resp ? inst : 32'h0;
        if (arm_flush && resp) begin
            bus.flush = 1'b1;
            arm_flush = 0;
            fired     = 1;
        end
        flushing = rdy && bus.flush;
        #1;
        ov_now       = bus.out_valid;
        req_now      = bus.ic_req_valid;
        req_addr_now = bus.ic_req_addr;
        if (fired) fire_ov = bus.out_valid;
        if (rdy) begin
            chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
            do_pop = (sb.size() != 0) && bus.out_ready && !flushing;
            if (do_pop) begin
                e = sb.pop_front();
                chk("out_pc", bus.out_pc, e.pc);
                chk("out_inst", bus.out_inst, e.inst);
                chk("out_pred_pc", bus.out_pred_pc, e.pred);
            end
            if (resp) begin
                ic_pend = 0;
                if (!disc && !flushing) begin
                    chk("bp_pc", bus.bp_pc, ic_addr);
                    chk("bp_inst", bus.bp_inst, inst);
                    sb.push_back('{pc: ic_addr, inst: inst, pred: pred_of(ic_addr)});
                    exp_pc = pred_of(ic_addr);
                end
                disc   = 0;
                ovr_en = 0;
            end
            if (flushing) begin
                sb.delete();
                exp_pc = {bus.flush_pc[31:2], 2'b00};
                if (ic_pend) disc = 1;
                chk("flush_no_req", 32'(req_now), 32'd0);
            end
            if (req_now) begin
                chk("req_addr", req_addr_now, exp_pc);
                chk("req_credit", 32'((sb.size() + int'(do_pop)) < DEPTH), 32'd1);
                chk("req_single", 32'(ic_pend), 32'd0);
                ic_pend = 1;
                ic_wait = lat;
                ic_addr = req_addr_now;
            end
        end
        @(negedge clk);
        if (fired) bus.flush = 1'b0;
    endtask

    initial begin
        bit          ok;
        logic [31:0] s_ov, s_pc, s_inst, s_pred, s_rv, s_ra, s_bp;

        rst = 1'b1;
        rdy = 1'b1;
        bus.flush = 1'b0;
        bus.flush_pc = '0;
        bus.ic_resp_valid = 1'b0;
        bus.ic_resp_inst = '0;
        bus.out_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.ic_req_valid), 32'd0);
        chk("rst_req_addr", bus.ic_req_addr, 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_inst", bus.out_inst, 32'h0);
        chk("rst_out_pred", bus.out_pred_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: latency-1 stream, sequential prediction
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t1_req_valid", 32'(req_now), 32'd1);
            chk("t1_req_addr", req_addr_now, 32'(i * 4));
        end
        repeat (4) cyc();

        // 2: consumer stalled, queue fills, credits stop requests
        bus.out_ready = 1'b0;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            cyc();
            ok = (sb.size() == DEPTH) && !ic_pend;
        end
        chk("t2_filled", 32'(ok), 32'd1);
        repeat (3) begin
            cyc();
            chk("t2_stall_noreq", 32'(req_now), 32'd0);
            chk("t2_full_valid", 32'(ov_now), 32'd1);
        end
        bus.out_ready = 1'b1;
        cyc();
        chk("t2_pop_cycle_noreq", 32'(req_now), 32'd0);
        bus.out_ready = 1'b0;
        cyc();
        chk("t2_req_after_pop", 32'(req_now), 32'd1);
        bus.out_ready = 1'b1;
        repeat (8) cyc();

        // 3: flush in WAIT, stale response dropped two cycles later
        lat = 3;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            cyc();
            ok = req_now;
        end
        chk("t3_req_seen", 32'(ok), 32'd1);
        lat = 1;
        ovr_en = 1;
        ovr_inst = 32'hDEAD;
        bus.flush = 1'b1;
        bus.flush_pc = 32'h103;
        cyc();
        bus.flush = 1'b0;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            cyc();
            ok = req_now;
            if (!ok) chk("t3_empty", 32'(ov_now), 32'd0);
        end
        chk("t3_req_after", 32'(ok), 32'd1);
        chk("t3_req_addr", req_addr_now, 32'h100);
        repeat (4) cyc();

        // 4: flush together with a response and a pop
        bus.flush_pc = 32'h3;
        arm_flush = 1;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            cyc();
            ok = fired;
        end
        chk("t4_fired", 32'(ok), 32'd1);
        chk("t4_head_valid", 32'(fire_ov), 32'd1);
        jump_en = 1;
        cyc();
        chk("t4_out_valid", 32'(ov_now), 32'd0);
        chk("t4_req_valid", 32'(req_now), 32'd1);
        chk("t4_req_addr", req_addr_now, 32'h0);

        // 5: predicted redirect 0x8 -> 0x40
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            cyc();
            ok = req_now && (req_addr_now == 32'h40);
        end
        chk("t5_jump_req", 32'(ok), 32'd1);
        repeat (3) cyc();

        // 6: rdy low for 5 cycles mid-stream
        rdy = 1'b0;
        cyc();
        s_ov = 32'(bus.out_valid); s_pc = bus.out_pc; s_inst = bus.out_inst;
        s_pred = bus.out_pred_pc; s_rv = 32'(bus.ic_req_valid);
        s_ra = bus.ic_req_addr; s_bp = bus.bp_pc;
        repeat (4) begin
            cyc();
            chk("t6_out_valid", 32'(bus.out_valid), s_ov);
            chk("t6_out_pc", bus.out_pc, s_pc);
            chk("t6_out_inst", bus.out_inst, s_inst);
            chk("t6_out_pred", bus.out_pred_pc, s_pred);
            chk("t6_req_valid", 32'(bus.ic_req_valid), s_rv);
            chk("t6_req_addr", bus.ic_req_addr, s_ra);
            chk("t6_bp_pc", bus.bp_pc, s_bp);
        end
        rdy = 1'b1;
        repeat (12) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
